// File: rtl/rx_frame_buf.sv
// Store-and-forward receive frame buffer: words are written speculatively and
// become visible to the AXI-Stream master side only once the whole frame commits.
module rx_frame_buf #(
   parameter int DEPTH     = 512,
   parameter int MAX_FRAME = 256
) (
   input  logic                    m_axis_aclk,
   input  logic                    m_axis_aresetn,
   input  logic                    s_axis_tvalid,
   input  logic [31:0]             s_axis_tdata,
   input  logic                    s_frame_end,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [31:0]             m_axis_tdata,
   output logic                    m_axis_tlast,
   input  logic                    ctrl_rst_cntr,
   output logic [31:0]             stat_frames_ok,
   output logic [31:0]             stat_frames_drop,
   output logic [$clog2(DEPTH):0]  stat_fill
);

   // state   | meaning
   // S_IDLE  | staging register empty, waiting for first word of a frame
   // S_FRAME | staging register holds the most recent word of the frame
   // S_DROP  | frame abandoned, discarding words until frame end
   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(MAX_FRAME + 1) + 1;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   state_t          state_q, state_d;
   logic [31:0]     stage_q, stage_d;
   logic [LW-1:0]   len_q, len_d;
   logic [PW-1:0]   wr_spec_q, wr_spec_d;
   logic [PW-1:0]   wr_cmt_q, wr_cmt_d;
   logic [PW-1:0]   vis_q;
   logic [PW-1:0]   rf_q;
   logic [PW-1:0]   rd_q;
   logic            tvalid_q;
   logic [31:0]     tdata_q;
   logic            tlast_q;
   logic [31:0]     ok_q;
   logic [31:0]     drop_q;
   logic [32:0]     mem_q [DEPTH];

   logic            mem_we;
   logic            mem_wlast;
   logic            ok_inc;
   logic            drop_inc;
   logic            fifo_full;
   logic            rd_avail;
   logic            out_load;

   assign fifo_full = ((wr_spec_q - rd_q) == PW'(DEPTH));

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q   <= S_IDLE;
         stage_q   <= '0;
         len_q     <= '0;
         wr_spec_q <= '0;
         wr_cmt_q  <= '0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         len_q     <= len_d;
         wr_spec_q <= wr_spec_d;
         wr_cmt_q  <= wr_cmt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      len_d     = len_q;
      wr_spec_d = wr_spec_q;
      wr_cmt_d  = wr_cmt_q;
      mem_we    = 1'b0;
      mem_wlast = 1'b0;
      ok_inc    = 1'b0;
      drop_inc  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // a word arriving together with frame end is discarded with the frame
            if (s_frame_end) begin
               drop_inc = 1'b1;
            end else if (s_axis_tvalid) begin
               stage_d = s_axis_tdata;
               len_d   = LW'(1);
               state_d = S_FRAME;
            end
         end
         S_FRAME: begin
            if (s_frame_end) begin
               // frame end already seen, so an overflow here drops straight to idle
               if (s_axis_tvalid || fifo_full) begin
                  wr_spec_d = wr_cmt_q;
                  drop_inc  = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_wlast = 1'b1;
                  wr_spec_d = wr_spec_q + PW'(1);
                  wr_cmt_d  = wr_spec_q + PW'(1);
                  ok_inc    = 1'b1;
               end
               len_d   = '0;
               state_d = S_IDLE;
            end else if (s_axis_tvalid) begin
               if (fifo_full || (len_q == LW'(MAX_FRAME))) begin
                  wr_spec_d = wr_cmt_q;
                  len_d     = '0;
                  state_d   = S_DROP;
               end else begin
                  mem_we    = 1'b1;
                  wr_spec_d = wr_spec_q + PW'(1);
                  stage_d   = s_axis_tdata;
                  len_d     = len_q + LW'(1);
               end
            end
         end
         S_DROP: begin
            if (s_frame_end) begin
               drop_inc = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge m_axis_aclk) begin
      if (mem_we) begin
         mem_q[wr_spec_q[AW-1:0]] <= {mem_wlast, stage_q};
      end
   end

   // vis_q delays the commit pointer one cycle so a commit reaches the output two edges later
   assign rd_avail = (rf_q != vis_q);
   assign out_load = rd_avail && (!tvalid_q || m_axis_tready);

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         vis_q    <= '0;
         rf_q     <= '0;
         rd_q     <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
      end else begin
         vis_q <= wr_cmt_q;
         if (out_load) begin
            tvalid_q           <= 1'b1;
            {tlast_q, tdata_q} <= mem_q[rf_q[AW-1:0]];
            rf_q               <= rf_q + PW'(1);
         end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
         end
         if (tvalid_q && m_axis_tready) begin
            rd_q <= rd_q + PW'(1);
         end
      end
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         ok_q   <= '0;
         drop_q <= '0;
      end else if (ctrl_rst_cntr) begin
         ok_q   <= '0;
         drop_q <= '0;
      end else begin
         if (ok_inc && (ok_q != CNT_MAX)) begin
            ok_q <= ok_q + 32'd1;
         end
         if (drop_inc && (drop_q != CNT_MAX)) begin
            drop_q <= drop_q + 32'd1;
         end
      end
   end

   assign m_axis_tvalid    = tvalid_q;
   assign m_axis_tdata     = tdata_q;
   assign m_axis_tlast     = tlast_q;
   assign stat_frames_ok   = ok_q;
   assign stat_frames_drop = drop_q;
   assign stat_fill        = wr_cmt_q - rd_q;

endmodule
